// File: rtl/calib_display_arbiter_pkg.sv
// Shared types and colour defaults for the calibration display arbiter.
`ifndef CALIB_DISPLAY_ARBITER_PKG_SV
`define CALIB_DISPLAY_ARBITER_PKG_SV

package calib_display_arbiter_pkg;

  // state  | meaning
  // PASS   | normal colour source owns the strand
  // FLUSH  | waiting out the strand in flight (may mix old/new pattern)
  // PUSH   | a complete strand of the new pattern is being shifted
  // SETTLE | counting camera frames while exposure settles
  // VALID  | pattern latched and settled, still being refreshed
  typedef enum logic [2:0] {
    PASS   = 3'd0,
    FLUSH  = 3'd1,
    PUSH   = 3'd2,
    SETTLE = 3'd3,
    VALID  = 3'd4
  } arbiter_state_t;

  localparam logic [23:0] ON_COLOR_DEF  = 24'hFFFFFF;
  localparam logic [23:0] OFF_COLOR_DEF = 24'h000000;

endpackage

`endif

// File: rtl/calib_display_arbiter_if.sv
// Request/response handshake between the LED strand driver and the arbiter.
interface calib_display_arbiter_if #(
  parameter int LED_ADDRESS_WIDTH = 6
) ();

  logic                         driver_ready_in;
  logic [LED_ADDRESS_WIDTH-1:0] driver_addr_in;
  logic                         strand_done_in;
  logic [23:0]                  color_out;
  logic                         color_valid_out;

  // Strand driver side: asks for colours, reports strand completion.
  modport master (
    output driver_ready_in,
    output driver_addr_in,
    output strand_done_in,
    input  color_out,
    input  color_valid_out
  );

  // Arbiter side: answers every request one cycle later.
  modport slave (
    input  driver_ready_in,
    input  driver_addr_in,
    input  strand_done_in,
    output color_out,
    output color_valid_out
  );

endinterface

// File: rtl/calib_display_arbiter_pattern_color.sv
// Combinational colour selection: normal source, or the calibration
// pattern built from one bit of the LED address.
module calib_pattern_color
  import calib_display_arbiter_pkg::*;
#(
  parameter int          NUM_LEDS               = 50,
  parameter int          LED_ADDRESS_WIDTH      = $clog2(NUM_LEDS),
  parameter int          LED_ADDR_BIT_SEL_WIDTH = $clog2(LED_ADDRESS_WIDTH),
  parameter logic [23:0] ON_COLOR               = ON_COLOR_DEF,
  parameter logic [23:0] OFF_COLOR              = OFF_COLOR_DEF
) (
  input  logic [LED_ADDRESS_WIDTH-1:0]      addr,
  input  logic [LED_ADDR_BIT_SEL_WIDTH-1:0] sel,
  input  logic                              pattern_mode,
  input  logic [23:0]                       normal_color,
  output logic [23:0]                       color
);

  logic addr_bit;

  // Pick the selected address bit; a select past the top bit or an address
  // past the end of the strand forces the LED dark.
  always_comb begin
    addr_bit = 1'b0;
    for (int i = 0; i < LED_ADDRESS_WIDTH; i++) begin
      if (int'(sel) == i) addr_bit = addr[i];
    end

    color = normal_color;
    if (pattern_mode) begin
      if (int'(sel) >= LED_ADDRESS_WIDTH || int'(addr) >= NUM_LEDS) begin
        color = OFF_COLOR;
      end else begin
        color = addr_bit ? ON_COLOR : OFF_COLOR;
      end
    end
  end

endmodule

// File: rtl/calib_display_arbiter.sv
// Shares the LED strand driver between the normal colour source and the
// calibration pattern, and reports when a new pattern is latched and the
// camera exposure has settled.
module calib_display_arbiter
  import calib_display_arbiter_pkg::*;
#(
  parameter int          NUM_LEDS               = 50,
  parameter int          LED_ADDRESS_WIDTH      = $clog2(NUM_LEDS),
  parameter int          LED_ADDR_BIT_SEL_WIDTH = $clog2(LED_ADDRESS_WIDTH),
  parameter int          SETTLE_FRAMES          = 2,
  parameter logic [23:0] ON_COLOR               = ON_COLOR_DEF,
  parameter logic [23:0] OFF_COLOR              = OFF_COLOR_DEF
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              calib_active_in,
  input  logic [LED_ADDR_BIT_SEL_WIDTH-1:0] bit_sel_in,
  input  logic                              bit_sel_start_in,
  output logic                              display_valid_out,
  input  logic [23:0]                       normal_color_in,
  calib_display_arbiter_if.slave            drv,
  input  logic                              frame_done_in,
  output logic [2:0]                        state_out
);

  localparam int CNT_W = $clog2(SETTLE_FRAMES + 1);

  arbiter_state_t                    state_q, state_d;
  logic [LED_ADDR_BIT_SEL_WIDTH-1:0] sel_q, sel_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic                              valid_q, valid_d;
  logic [23:0]                       color_q, color_next;
  logic                              color_valid_q;

  calib_pattern_color #(
    .NUM_LEDS              (NUM_LEDS),
    .LED_ADDRESS_WIDTH     (LED_ADDRESS_WIDTH),
    .LED_ADDR_BIT_SEL_WIDTH(LED_ADDR_BIT_SEL_WIDTH),
    .ON_COLOR              (ON_COLOR),
    .OFF_COLOR             (OFF_COLOR)
  ) u_pattern_color (
    .addr        (drv.driver_addr_in),
    .sel         (sel_q),
    .pattern_mode(state_q != PASS),
    .normal_color(normal_color_in),
    .color       (color_next)
  );

  // State, latched select, frame counter and the registered valid flag.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= PASS;
      sel_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  // Next state: abort beats restart, restart beats any strand/frame event.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;

    if (state_q != PASS && !calib_active_in) begin
      state_d = PASS;
    end else if (state_q != PASS && bit_sel_start_in) begin
      sel_d   = bit_sel_in;
      cnt_d   = '0;
      state_d = FLUSH;
    end else begin
      unique case (state_q)
        PASS: begin
          if (bit_sel_start_in && calib_active_in) begin
            sel_d   = bit_sel_in;
            cnt_d   = '0;
            state_d = FLUSH;
          end
        end
        FLUSH: begin
          if (drv.strand_done_in) state_d = PUSH;
        end
        PUSH: begin
          if (drv.strand_done_in) begin
            cnt_d   = '0;
            state_d = SETTLE;
          end
        end
        SETTLE: begin
          if (frame_done_in) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(SETTLE_FRAMES - 1)) state_d = VALID;
          end
        end
        VALID: begin
          state_d = VALID;
        end
        default: state_d = PASS;
      endcase
    end

    valid_d = (state_d == VALID);
  end

  // Colour response: every driver request is answered exactly one cycle later.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      color_q       <= '0;
      color_valid_q <= 1'b0;
    end else begin
      color_valid_q <= drv.driver_ready_in;
      if (drv.driver_ready_in) color_q <= color_next;
    end
  end

  assign drv.color_out       = color_q;
  assign drv.color_valid_out = color_valid_q;
  assign display_valid_out   = valid_q;
  assign state_out           = state_q;

endmodule

// File: tb/tb_calib_display_arbiter.sv
// Scoreboard bench for calib_display_arbiter with an 8-LED strand.
module tb_calib_display_arbiter;
  import calib_display_arbiter_pkg::*;

  localparam int NL = 8;
  localparam int AW = 3;
  localparam int SW = 2;
  localparam int SF = 2;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          calib_active_in;
  logic [SW-1:0] bit_sel_in;
  logic          bit_sel_start_in;
  logic          display_valid_out;
  logic [23:0]   normal_color_in;
  logic          frame_done_in;
  logic [2:0]    state_out;

  calib_display_arbiter_if #(.LED_ADDRESS_WIDTH(AW)) drv ();

  calib_display_arbiter #(
    .NUM_LEDS     (NL),
    .SETTLE_FRAMES(SF)
  ) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .calib_active_in  (calib_active_in),
    .bit_sel_in       (bit_sel_in),
    .bit_sel_start_in (bit_sel_start_in),
    .display_valid_out(display_valid_out),
    .normal_color_in  (normal_color_in),
    .drv              (drv),
    .frame_done_in    (frame_done_in),
    .state_out        (state_out)
  );

  always #5 clk_in = ~clk_in;

  logic [23:0] sb_q[$];
  bit          push_now;
  bit          push_last;
  int          n_cmp;
  int          n_err;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected pattern colour, computed arithmetically from the address.
  function automatic logic [23:0] exp_pat(input int sel, input int addr);
    if (sel >= AW || addr >= NL) return 24'h000000;
    return (((addr / (1 << sel)) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
  endfunction

  // One clock: DUT samples the current inputs, then outputs are checked and
  // all single-cycle pulses are dropped.
  task automatic tick();
    @(posedge clk_in);
    #1;
    push_last = push_now;
    push_now  = 1'b0;
    if (push_last || drv.color_valid_out === 1'b1)
      check_val("color_valid", {31'd0, drv.color_valid_out}, {31'd0, push_last});
    if (push_last && sb_q.size() > 0)
      check_val("color", {8'd0, drv.color_out}, {8'd0, sb_q.pop_front()});
    drv.driver_ready_in = 1'b0;
    drv.strand_done_in  = 1'b0;
    bit_sel_start_in    = 1'b0;
    frame_done_in       = 1'b0;
  endtask

  task automatic req(input int addr, input logic [23:0] exp);
    drv.driver_addr_in  = AW'(addr);
    drv.driver_ready_in = 1'b1;
    sb_q.push_back(exp);
    push_now = 1'b1;
    tick();
  endtask

  task automatic start(input int sel);
    bit_sel_in       = SW'(sel);
    bit_sel_start_in = 1'b1;
    tick();
  endtask

  task automatic strand();
    drv.strand_done_in = 1'b1;
    tick();
  endtask

  task automatic frame();
    frame_done_in = 1'b1;
    tick();
  endtask

  task automatic check_state(input string tag, input arbiter_state_t exp_st, input logic exp_valid);
    check_val({tag, "_state"}, {29'd0, state_out}, {29'd0, exp_st});
    check_val({tag, "_valid"}, {31'd0, display_valid_out}, {31'd0, exp_valid});
  endtask

  // From FLUSH: two strands, then SF frames, valid one cycle after the last.
  task automatic run_to_valid(input string tag);
    strand();
    check_state({tag, "_s1"}, PUSH, 1'b0);
    strand();
    check_state({tag, "_s2"}, SETTLE, 1'b0);
    frame();
    check_state({tag, "_f1"}, SETTLE, 1'b0);
    frame();
    check_state({tag, "_f2"}, VALID, 1'b1);
  endtask

  initial begin
    n_cmp               = 0;
    n_err               = 0;
    push_now            = 1'b0;
    push_last           = 1'b0;
    rst_in              = 1'b1;
    calib_active_in     = 1'b0;
    bit_sel_in          = '0;
    bit_sel_start_in    = 1'b0;
    normal_color_in     = 24'h00FF00;
    frame_done_in       = 1'b0;
    drv.driver_ready_in = 1'b0;
    drv.driver_addr_in  = '0;
    drv.strand_done_in  = 1'b0;

    repeat (3) tick();
    check_state("rst", PASS, 1'b0);
    check_val("rst_color", {8'd0, drv.color_out}, 32'd0);
    check_val("rst_cv", {31'd0, drv.color_valid_out}, 32'd0);
    rst_in = 1'b0;
    tick();

    // Pass-through
    req(5, 24'h00FF00);
    check_val("pass_dv", {31'd0, display_valid_out}, 32'd0);
    tick();
    check_val("pass_cv_pulse", {31'd0, drv.color_valid_out}, 32'd0);
    normal_color_in = 24'h123456;
    req(2, 24'h123456);
    start(1);
    check_state("start_inactive", PASS, 1'b0);

    // Nominal pattern, sel=1
    calib_active_in = 1'b1;
    normal_color_in = 24'h00FF00;
    tick();
    start(1);
    check_state("nom_start", FLUSH, 1'b0);
    frame();
    check_state("nom_flush_frame", FLUSH, 1'b0);
    strand();
    check_state("nom_push", PUSH, 1'b0);
    for (int a = 0; a < NL; a++) req(a, exp_pat(1, a));
    strand();
    check_state("nom_settle", SETTLE, 1'b0);
    frame();
    check_state("nom_f1", SETTLE, 1'b0);
    frame();
    check_state("nom_valid", VALID, 1'b1);
    req(6, 24'hFFFFFF);
    check_state("nom_hold", VALID, 1'b1);

    // Restart in VALID with sel=2
    start(2);
    check_state("rst_valid", FLUSH, 1'b0);
    req(4, 24'hFFFFFF);
    req(3, 24'h000000);
    run_to_valid("restart");

    // Start together with strand_done in VALID and in PUSH
    bit_sel_in         = 2'd0;
    bit_sel_start_in   = 1'b1;
    drv.strand_done_in = 1'b1;
    tick();
    check_state("sim_valid", FLUSH, 1'b0);
    strand();
    check_state("sim_push", PUSH, 1'b0);
    bit_sel_in         = 2'd1;
    bit_sel_start_in   = 1'b1;
    drv.strand_done_in = 1'b1;
    tick();
    check_state("sim_push_start", FLUSH, 1'b0);
    strand();
    check_state("sim_push2", PUSH, 1'b0);
    // strand_done with frame_done in PUSH: counter starts at 0
    drv.strand_done_in = 1'b1;
    frame_done_in      = 1'b1;
    tick();
    check_state("sim_sf", SETTLE, 1'b0);
    frame();
    check_state("sim_sf_f1", SETTLE, 1'b0);
    frame();
    check_state("sim_sf_f2", VALID, 1'b1);

    // Abort in SETTLE
    start(0);
    strand();
    strand();
    frame();
    check_state("abort_pre", SETTLE, 1'b0);
    calib_active_in = 1'b0;
    tick();
    check_state("abort", PASS, 1'b0);
    req(7, 24'h00FF00);

    // Abort in VALID drops valid on the same edge
    calib_active_in = 1'b1;
    start(2);
    run_to_valid("abort2");
    calib_active_in = 1'b0;
    tick();
    check_state("abort_valid", PASS, 1'b0);

    // Reset in PUSH
    calib_active_in = 1'b1;
    start(0);
    strand();
    check_state("rpush_pre", PUSH, 1'b0);
    req(1, 24'hFFFFFF);
    rst_in = 1'b1;
    tick();
    check_state("rpush", PASS, 1'b0);
    check_val("rpush_color", {8'd0, drv.color_out}, 32'd0);
    check_val("rpush_cv", {31'd0, drv.color_valid_out}, 32'd0);
    rst_in = 1'b0;
    tick();

    // Out-of-range select
    start(3);
    check_state("oor_start", FLUSH, 1'b0);
    strand();
    for (int a = 0; a < NL; a++) req(a, 24'h000000);
    strand();
    check_state("oor_settle", SETTLE, 1'b0);
    frame();
    frame();
    check_state("oor_valid", VALID, 1'b1);
    req(5, exp_pat(3, 5));

    tick();
    check_val("sb_empty", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
